dem_recombiner: RTL and testbench

//  Inverse of the three-layer switching tree: takes the 8 third-layer element codes, sums them

---
 rtl/dem_recombiner_pkg.sv | 25 ++
 rtl/dem_recombiner_if.sv | 43 ++++
 rtl/dem_delay_line.sv | 43 ++++
 rtl/dem_recombiner.sv | 117 +++++++++++
 tb/tb_dem_recombiner.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/dem_recombiner_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dem_recombiner_pkg
//  Description : Shared sizes and types for the DEM recombiner monitor.
//                INPUT_WIDTH is the width of one element code and of the
//                tree-input reference code; SUM_W holds the sum of all
//                NUM_ELEM codes without truncation.
//  Revision    : 1.0 - initial release
// ============================================================================
package dem_recombiner_pkg;

  localparam int INPUT_WIDTH = 4;
  localparam int NUM_ELEM    = 8;
  localparam int SUM_W       = INPUT_WIDTH + 3;

  typedef logic [INPUT_WIDTH-1:0] elem_code_t;
  typedef logic [SUM_W-1:0]       sum_t;

  // The reference is unsigned, so widening is a plain zero-extension.
  function automatic sum_t zext_ref(input elem_code_t code);
    return sum_t'(code);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dem_recombiner_if.sv
`default_nettype none
// ============================================================================
//  Module      : dem_recombiner_if
//  Description : Bundle of the recombiner data/status signals.
//    valid_i      : x_seg_i qualifies this cycle
//    x_ref_i      : code applied to the tree input
//    x_seg_i      : element codes, elem k at [k*INPUT_WIDTH +: INPUT_WIDTH]
//    clear_i      : synchronous clear of counters and sticky flag
//    sum_o        : recombined sum          sum_valid_o : sum_o/mismatch_o valid
//    mismatch_o   : sum differs from ref    err_sticky_o: any mismatch seen
//    err_cnt_o    : saturating mismatch count
//    act_cnt_o    : per-element saturating activity counts
//    master drives the inputs, slave is the recombiner.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dem_recombiner_if
  import dem_recombiner_pkg::*;
#(
  parameter int ERR_W = 16,
  parameter int ACT_W = 12
);
  logic                            valid_i;
  elem_code_t                      x_ref_i;
  logic [NUM_ELEM*INPUT_WIDTH-1:0] x_seg_i;
  logic                            clear_i;
  sum_t                            sum_o;
  logic                            sum_valid_o;
  logic                            mismatch_o;
  logic                            err_sticky_o;
  logic [ERR_W-1:0]                err_cnt_o;
  logic [NUM_ELEM*ACT_W-1:0]       act_cnt_o;

  modport master (
    output valid_i, x_ref_i, x_seg_i, clear_i,
    input  sum_o, sum_valid_o, mismatch_o, err_sticky_o, err_cnt_o, act_cnt_o
  );

  modport slave (
    input  valid_i, x_ref_i, x_seg_i, clear_i,
    output sum_o, sum_valid_o, mismatch_o, err_sticky_o, err_cnt_o, act_cnt_o
  );
endinterface
`default_nettype wire

// File: rtl/dem_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : dem_delay_line
//  Description : Free-running shift register, DEPTH stages of WIDTH bits.
//                DEPTH=0 is a combinational pass-through.
//    clk_i   : clock, rising edge
//    reset_i : asynchronous active-low reset, clears all stages
//    din     : data in        dout : data delayed by DEPTH cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module dem_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk_rst;
      assign unused_clk_rst = clk_i ^ reset_i;
      assign dout           = din;
    end else begin : g_shift
      logic [WIDTH-1:0] stage [DEPTH];

      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
          stage[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
      end

      assign dout = stage[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/dem_recombiner.sv
`default_nettype none
// ============================================================================
//  Module      : dem_recombiner
//  Description : Sums the 8 third-layer DEM element codes in a 3-stage
//                adder tree, compares the total with the tree-input code
//                delayed to line up with it, and keeps a saturating
//                mismatch counter, sticky error flag and per-element
//                activity counters.
//    clk_i   : clock, rising edge
//    reset_i : asynchronous active-low reset
//    bus     : dem_recombiner_if.slave (data in, sum/status out)
//  Revision    : 1.0 - initial release
// ============================================================================
module dem_recombiner
  import dem_recombiner_pkg::*;
#(
  parameter int REF_DELAY = 2,
  parameter int ERR_W     = 16,
  parameter int ACT_W     = 12
) (
  input  logic            clk_i,
  input  logic            reset_i,
  dem_recombiner_if.slave bus
);

  elem_code_t             seg      [NUM_ELEM];
  logic [INPUT_WIDTH:0]   s1_sum   [NUM_ELEM/2];
  logic [INPUT_WIDTH+1:0] s2_sum   [NUM_ELEM/4];
  sum_t                   s3_sum;
  logic [2:0]             vld_pipe;   // bit n = valid of stage n+1
  elem_code_t             ref_dly;
  elem_code_t             ref_s1, ref_s2, ref_s3;
  logic                   mismatch;
  logic [ERR_W-1:0]       err_cnt;
  logic                   err_sticky;
  logic [ACT_W-1:0]       act_cnt  [NUM_ELEM];

  generate
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_unpack
      assign seg[k] = bus.x_seg_i[k*INPUT_WIDTH +: INPUT_WIDTH];
    end
  endgenerate

  dem_delay_line #(
    .WIDTH (INPUT_WIDTH),
    .DEPTH (REF_DELAY)
  ) u_ref_dly (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .din     (bus.x_ref_i),
    .dout    (ref_dly)
  );

  // Adder tree with the reference riding alongside so both reach stage 3
  // together. Data registers load every clock; the valid bit qualifies them.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_pipe <= '0;
      for (int i = 0; i < NUM_ELEM/2; i++) s1_sum[i] <= '0;
      for (int i = 0; i < NUM_ELEM/4; i++) s2_sum[i] <= '0;
      s3_sum <= '0;
      ref_s1 <= '0;
      ref_s2 <= '0;
      ref_s3 <= '0;
    end else begin
      vld_pipe <= {vld_pipe[1:0], bus.valid_i};
      for (int i = 0; i < NUM_ELEM/2; i++)
        s1_sum[i] <= {1'b0, seg[2*i]} + {1'b0, seg[2*i+1]};
      for (int i = 0; i < NUM_ELEM/4; i++)
        s2_sum[i] <= {1'b0, s1_sum[2*i]} + {1'b0, s1_sum[2*i+1]};
      s3_sum <= {1'b0, s2_sum[0]} + {1'b0, s2_sum[1]};
      ref_s1 <= ref_dly;
      ref_s2 <= ref_s1;
      ref_s3 <= ref_s2;
    end
  end

  assign mismatch = vld_pipe[2] & (s3_sum != zext_ref(ref_s3));

  // clear_i has priority: a mismatch on the same edge is dropped.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (bus.clear_i) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (mismatch) begin
      err_sticky <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
    end
  end

  // Activity is counted on the raw input, not the pipelined copy.
  generate
    for (genvar k = 0; k < NUM_ELEM; k++) begin : g_act
      always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
          act_cnt[k] <= '0;
        end else if (bus.clear_i) begin
          act_cnt[k] <= '0;
        end else if (bus.valid_i && (seg[k] != '0) && (act_cnt[k] != '1)) begin
          act_cnt[k] <= act_cnt[k] + ACT_W'(1);
        end
      end
      assign bus.act_cnt_o[k*ACT_W +: ACT_W] = act_cnt[k];
    end
  endgenerate

  assign bus.sum_o        = s3_sum;
  assign bus.sum_valid_o  = vld_pipe[2];
  assign bus.mismatch_o   = mismatch;
  assign bus.err_sticky_o = err_sticky;
  assign bus.err_cnt_o    = err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_dem_recombiner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dem_recombiner
//  Description : Self-checking bench for dem_recombiner (REF_DELAY=2,
//                4-bit counters so saturation is reachable).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dem_recombiner;
  import dem_recombiner_pkg::*;

  localparam int ERR_W = 4;
  localparam int ACT_W = 4;

  logic clk;
  logic reset_n;

  dem_recombiner_if #(.ERR_W(ERR_W), .ACT_W(ACT_W)) bus ();

  dem_recombiner #(
    .REF_DELAY (2),
    .ERR_W     (ERR_W),
    .ACT_W     (ACT_W)
  ) dut (
    .clk_i   (clk),
    .reset_i (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] sum;
    logic       mm;
    int         due;
  } exp_t;

  typedef struct {
    logic        v;
    logic [3:0]  xr;
    logic [31:0] segs;
    logic [6:0]  es;
  } vec_t;

  exp_t       sbq[$];
  int         checks   = 0;
  int         failures = 0;
  int         ecnt     = 0;
  logic [3:0] h1, h2;
  logic [3:0] m_err;
  logic       m_sticky;
  logic [3:0] m_act [8];
  logic       mm_now;
  vec_t       tbl [13];

  function automatic logic [31:0] pk(input int s0, input int s1, input int s2, input int s3,
                                     input int s4, input int s5, input int s6, input int s7);
    return {s7[3:0], s6[3:0], s5[3:0], s4[3:0], s3[3:0], s2[3:0], s1[3:0], s0[3:0]};
  endfunction

  function automatic logic [6:0] ssum(input logic [31:0] s);
    int t = 0;
    for (int k = 0; k < 8; k++) t += int'(s[k*4 +: 4]);
    return 7'(t);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    sbq.delete();
    h1 = '0; h2 = '0;
    m_err = '0; m_sticky = 1'b0; mm_now = 1'b0;
    for (int k = 0; k < 8; k++) m_act[k] = '0;
  endtask

  task automatic compare();
    exp_t e;
    if (sbq.size() > 0 && sbq[0].due == ecnt) begin
      e = sbq.pop_front();
      check("sum_valid", 32'(bus.sum_valid_o), 32'd1);
      check("sum", 32'(bus.sum_o), 32'(e.sum));
      check("mismatch", 32'(bus.mismatch_o), 32'(e.mm));
      mm_now = e.mm;
    end else begin
      check("sum_valid_idle", 32'(bus.sum_valid_o), 32'd0);
      check("mismatch_idle", 32'(bus.mismatch_o), 32'd0);
      mm_now = 1'b0;
    end
    check("err_cnt", 32'(bus.err_cnt_o), 32'(m_err));
    check("err_sticky", 32'(bus.err_sticky_o), 32'(m_sticky));
    for (int k = 0; k < 8; k++)
      check($sformatf("act_cnt%0d", k), 32'(bus.act_cnt_o[k*ACT_W +: ACT_W]), 32'(m_act[k]));
  endtask

  // Called at a negedge: drive, clock, update model, compare at next negedge.
  task automatic step(input logic v, input logic [3:0] xr, input logic [31:0] segs,
                      input logic clr, input logic [6:0] es);
    bus.valid_i = v;
    bus.x_ref_i = xr;
    bus.x_seg_i = segs;
    bus.clear_i = clr;
    @(posedge clk);
    ecnt++;
    if (v) sbq.push_back('{sum: es, mm: (es != {3'b000, h2}), due: ecnt + 2});
    h2 = h1;
    h1 = xr;
    if (clr) begin
      m_err = '0;
      m_sticky = 1'b0;
      for (int k = 0; k < 8; k++) m_act[k] = '0;
    end else begin
      if (mm_now) begin
        m_sticky = 1'b1;
        if (m_err != 4'hF) m_err++;
      end
      for (int k = 0; k < 8; k++)
        if (v && segs[k*4 +: 4] != 4'd0 && m_act[k] != 4'hF) m_act[k]++;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_sum"},    32'(bus.sum_o), 32'd0);
    check({tag, "_valid"},  32'(bus.sum_valid_o), 32'd0);
    check({tag, "_mm"},     32'(bus.mismatch_o), 32'd0);
    check({tag, "_sticky"}, 32'(bus.err_sticky_o), 32'd0);
    check({tag, "_err"},    32'(bus.err_cnt_o), 32'd0);
    check({tag, "_act"},    32'(bus.act_cnt_o), 32'd0);
  endtask

  logic [31:0] good, bad, s5, s7, junk, s3only;

  initial begin
    good   = pk(2, 2, 2, 2, 2, 1, 1, 1);   // 13
    bad    = pk(3, 2, 2, 2, 2, 1, 1, 1);   // 14
    s5     = pk(1, 0, 2, 0, 0, 1, 1, 0);   // 5
    s7     = pk(0, 3, 0, 0, 4, 0, 0, 0);   // 7
    junk   = pk(9, 9, 2, 0, 0, 0, 0, 0);   // 20, presented on a bubble
    s3only = pk(0, 0, 0, 1, 0, 0, 0, 0);   // 1

    // Steady stream then one injected error (sum 14 vs ref 13).
    tbl[0] = '{v: 1'b0, xr: 4'd13, segs: 32'd0, es: 7'd0};
    tbl[1] = '{v: 1'b0, xr: 4'd13, segs: 32'd0, es: 7'd0};
    for (int i = 2; i < 8; i++) tbl[i] = '{v: 1'b1, xr: 4'd13, segs: good, es: 7'd13};
    tbl[8] = '{v: 1'b1, xr: 4'd13, segs: bad, es: 7'd14};
    for (int i = 9; i < 13; i++) tbl[i] = '{v: 1'b1, xr: 4'd13, segs: good, es: 7'd13};

    reset_n     = 1'b0;
    bus.valid_i = 1'b0;
    bus.x_ref_i = '0;
    bus.x_seg_i = '0;
    bus.clear_i = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Tests 1 and 2: table-driven.
    for (int i = 0; i < 13; i++) step(tbl[i].v, tbl[i].xr, tbl[i].segs, 1'b0, tbl[i].es);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd13, 32'd0, 1'b0, 7'd0);
    check("t2_err_cnt", 32'(bus.err_cnt_o), 32'd1);
    check("t2_sticky", 32'(bus.err_sticky_o), 32'd1);

    // Test 5: clear on the cycle a mismatch is visible.
    step(1'b1, 4'd13, bad, 1'b0, ssum(bad));
    step(1'b0, 4'd13, 32'd0, 1'b0, 7'd0);
    step(1'b0, 4'd13, 32'd0, 1'b0, 7'd0);
    check("t5_mm_visible", 32'(bus.mismatch_o), 32'd1);
    step(1'b0, 4'd13, 32'd0, 1'b1, 7'd0);
    check("t5_err_cleared", 32'(bus.err_cnt_o), 32'd0);
    check("t5_sticky_cleared", 32'(bus.err_sticky_o), 32'd0);

    // Test 4: gapped valid with a garbage bubble; reference lined up.
    step(1'b0, 4'd5, 32'd0, 1'b0, 7'd0);
    step(1'b0, 4'd0, 32'd0, 1'b0, 7'd0);
    step(1'b1, 4'd7, s5, 1'b0, ssum(s5));
    step(1'b0, 4'd13, junk, 1'b0, 7'd0);
    step(1'b1, 4'd13, s7, 1'b0, ssum(s7));
    for (int i = 0; i < 3; i++) step(1'b0, 4'd13, 32'd0, 1'b0, 7'd0);
    check("t4_no_err", 32'(bus.err_cnt_o), 32'd0);

    // Test 3: 20 consecutive mismatches, seg3 active each time.
    for (int i = 0; i < 20; i++) step(1'b1, 4'd13, s3only, 1'b0, ssum(s3only));
    for (int i = 0; i < 3; i++) step(1'b0, 4'd13, 32'd0, 1'b0, 7'd0);
    check("t3_err_sat", 32'(bus.err_cnt_o), 32'd15);
    check("t3_act3_sat", 32'(bus.act_cnt_o[3*ACT_W +: ACT_W]), 32'd15);

    // Test 6: reset mid-burst, then restart.
    for (int i = 0; i < 4; i++) step(1'b1, 4'd13, good, 1'b0, 7'd13);
    check("t6_busy_before_reset", 32'(bus.sum_valid_o), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    model_clear();
    bus.valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 4'd13, 32'd0, 1'b0, 7'd0);
    step(1'b0, 4'd13, 32'd0, 1'b0, 7'd0);
    step(1'b1, 4'd13, good, 1'b0, 7'd13);
    check("t6_lat1", 32'(bus.sum_valid_o), 32'd0);
    step(1'b1, 4'd11, pk(4, 4, 3, 0, 0, 0, 0, 0), 1'b0, 7'd11);
    check("t6_lat2", 32'(bus.sum_valid_o), 32'd0);
    step(1'b0, 4'd0, 32'd0, 1'b0, 7'd0);
    check("t6_lat3", 32'(bus.sum_valid_o), 32'd1);
    check("t6_first_sum", 32'(bus.sum_o), 32'd13);
    for (int i = 0; i < 3; i++) step(1'b0, 4'd0, 32'd0, 1'b0, 7'd0);
    check("sb_drain", 32'(sbq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
